coef_calc: RTL and testbench
============================

# coef_calc

Streaming least-squares coefficient unit for the linear-regression datapath. It consumes the (x, y) sample stream that the data-load stage replays from its buffer and accumulates Σx, Σy, Σxy, Σx² and n. On the final sample it computes slope b1 and intercept b0 with a shared iterative divider. It then reports completion with a one-cycle `done` pulse so the load stage can continue with the error pass.

## Interface
- `DW`, 20: sample and coefficient width, signed two's complement.
- `FRAC`, 10: fractional bits. Samples and coefficients are Q(DW-FRAC).FRAC.
- `CW`, 8: sample-counter width. At most 2^CW-1 samples are accepted.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle pulse. Clears the accumulators and arms the block for a new stream.
- `en` input 1: sample valid. `inx`/`iny` are sampled on the rising edge while `en`=1.
- `last` input 1: qualified by `en`. Marks the final sample of the stream.
- `inx` input DW: x sample.
- `iny` input DW: y sample.
- `busy` output 1: high from `start` until `done`.
- `done` output 1: one-cycle pulse. Outputs are valid from this cycle onward.
- `degen` output 1: denominator was zero (n<2 or all x equal). Valid with `done`.
- `ovf` output 1: a sample arrived after the count reached 2^CW-1 and was dropped. Sticky until `start`.
- `b1` output DW: slope, Q10.10.
- `b0` output DW: intercept, Q10.10.
- `cnt` output CW: number of samples accumulated so far (n).

## Operation
- Reset (`rst`=0, asynchronous): state IDLE. All outputs are 0 and all accumulators are 0.
- States:
  - IDLE: wait for `start`.
  - ACC: accumulate samples; exit on `en`&`last`.
  - PREP1: register num/den.
  - DIV1: compute b1.
  - PREP2: register the b0 numerator.
  - DIV2: compute b0.
  - DONE: assert `done`, return to IDLE.
- `start` in any state → ACC. Accumulators, `cnt`, `ovf`, `degen` are cleared; `b0`/`b1` clear to 0. `start` aborts any computation in progress. A sample presented in the same cycle as `start` is dropped.
- In ACC, each `en` adds inx to Sx, iny to Sy, inx·iny to Sxy, inx² to Sxx, and 1 to `cnt`.
  - Products are full 2·DW-bit signed values. Accumulators are sign-extended by CW bits, so they never overflow.
  - When `cnt`=2^CW-1, a further `en` sets `ovf` and does not modify any sum. `last` on that dropped sample still ends the stream.
- `en` outside ACC is ignored.
- PREP1 computes (all Q·20 scale, signed, 96-bit internal):
  - num = n·Sxy − Sx·Sy
  - den = n·Sxx − Sx²
- DIV1 computes b1 = (num·2^FRAC)/den. It uses a sign-magnitude restoring divider, 1 quotient bit per cycle, 96 iterations, and truncates toward zero.
- If den=0: skip the divider result, b1=0, `degen`=1. State timing is unchanged.
- PREP2 computes b0num = Sy − ((b1·Sx) >>> FRAC), using an arithmetic shift.
- DIV2 computes b0 = b0num/n with the same divider, truncating toward zero.
- Both quotients saturate to [−2^(DW−1), 2^(DW−1)−1] before they are registered.
- If n=0 (`last` arrived only on dropped samples, which is impossible unless CW is degenerate): b0=0, b1=0, `degen`=1.

## Timing
- Accumulation throughput: one sample per clock, no back-pressure.
- Let E be the edge that samples `en`&`last`.
  - PREP1 is the cycle after E.
  - DIV1 takes the next 96 cycles.
  - PREP2 takes 1 cycle.
  - DIV2 takes 96 cycles.
  - `done`=1 in the 195th cycle after E, i.e. registered on edge E+195.
- `b0`, `b1`, `degen` update on the same edge `done` rises. They hold until the next `start` or reset.
- `busy` rises on the edge after `start` and falls on the edge that ends DONE.
- `done` is never asserted twice for one stream.
- Reset mid-operation returns the block to IDLE immediately; no `done` is produced.

## Test plan
- Fit y=2x+1. Stimulus: `start`, then x=0,1024,2048,3072 and y=1024,3072,5120,7168, `last` on the 4th sample. Required response: `done` at E+195, b1=2048, b0=1024, degen=0, cnt=4.
- Negative slope. Stimulus: x=0..4 (·1024), y=5120,4096,3072,2048,1024. Required response: b1=−1024, b0=5120.
- Constant x. Stimulus: x=1024 for three samples, y=1024,2048,3072. Required response: degen=1, b1=0, b0=2048.
- Single sample. Stimulus: one sample x=3072, y=5120 with `last`. Required response: degen=1, b1=0, b0=5120.
- Abort and reset:
  - Assert `rst`=0 during DIV1. Required response: all outputs 0, IDLE, no `done`.
  - Issue `start` during DIV2. Required response: accumulators cleared, the new stream completes correctly, only one `done`.
- Overflow, with CW=8. Stimulus: 256 samples of x=1024, y=1024, `last` on the 256th. Required response: cnt=255, ovf=1, degen=1, b0=1024.

Source files
------------

// File: rtl/coef_calc_if.sv
// Stream/result bundle between the data-load stage and coef_calc.
interface coef_calc_if #(
  parameter int unsigned DW = 20,
  parameter int unsigned CW = 8
);
  logic          start;
  logic          en;
  logic          last;
  logic [DW-1:0] inx;
  logic [DW-1:0] iny;
  logic          busy;
  logic          done;
  logic          degen;
  logic          ovf;
  logic [DW-1:0] b1;
  logic [DW-1:0] b0;
  logic [CW-1:0] cnt;

  modport master (
    output start, en, last, inx, iny,
    input  busy, done, degen, ovf, b1, b0, cnt
  );

  modport slave (
    input  start, en, last, inx, iny,
    output busy, done, degen, ovf, b1, b0, cnt
  );
endinterface

// File: rtl/coef_calc.sv
// Streaming least-squares fit: accumulates sums over (x, y) samples, then
// derives slope and intercept with one shared 96-step restoring divider.
module coef_calc #(
  parameter int unsigned DW   = 20,
  parameter int unsigned FRAC = 10,
  parameter int unsigned CW   = 8
) (
  input logic        clk,
  input logic        rst,
  coef_calc_if.slave bus
);
  localparam int unsigned SW = DW + CW;
  localparam int unsigned PW = 2 * DW + CW;
  localparam int unsigned IW = 96;
  localparam logic [6:0]    LAST_IT = 7'(IW - 1);
  localparam logic [IW-1:0] LIM     = IW'(1) << (DW - 1);

  typedef enum logic [2:0] {IDLE, ACC, PREP1, DIV1, PREP2, DIV2, DONE} state_t;

  state_t               state;
  logic signed [SW-1:0] sx, sy;
  logic signed [PW-1:0] sxy, sxx;
  logic [IW:0]          rem;
  logic [IW-1:0]        quo, dvs;
  logic [6:0]           it;
  logic                 neg, den_zero, n_zero;
  logic [DW-1:0]        q1;

  logic signed [DW-1:0] xs, ys;
  logic signed [PW-1:0] pxy, pxx;
  logic signed [IW-1:0] n_w, sx_w, sy_w, sxy_w, sxx_w, num, den, q1_w, b0num;
  logic [IW-1:0]        num_mag, den_mag, b0_mag, quo_nx;
  logic [IW:0]          rem_sh, rem_nx;
  logic                 ge;
  logic [DW-1:0]        q1_c;

  function automatic logic [DW-1:0] sat(input logic [IW-1:0] mag, input logic sgn);
    if (mag >= LIM) return sgn ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return sgn ? -mag[DW-1:0] : mag[DW-1:0];
  endfunction

  always_comb begin
    xs      = $signed(bus.inx);
    ys      = $signed(bus.iny);
    pxy     = PW'(xs) * PW'(ys);
    pxx     = PW'(xs) * PW'(xs);
    n_w     = IW'(bus.cnt);
    sx_w    = IW'(sx);
    sy_w    = IW'(sy);
    sxy_w   = IW'(sxy);
    sxx_w   = IW'(sxx);
    num     = n_w * sxy_w - sx_w * sy_w;
    den     = n_w * sxx_w - sx_w * sx_w;
    num_mag = num[IW-1] ? -num : num;
    den_mag = den[IW-1] ? -den : den;
    rem_sh  = {rem[IW-1:0], quo[IW-1]};
    ge      = rem_sh >= {1'b0, dvs};
    rem_nx  = ge ? rem_sh - {1'b0, dvs} : rem_sh;
    quo_nx  = {quo[IW-2:0], ge};
    // Slope is taken straight from the divider so the intercept numerator
    // can be formed in the same cycle the slope is latched.
    q1_c    = den_zero ? '0 : sat(quo, neg);
    q1_w    = IW'($signed(q1_c));
    b0num   = sy_w - ((q1_w * sx_w) >>> FRAC);
    b0_mag  = b0num[IW-1] ? -b0num : b0num;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sx        <= '0;
      sy        <= '0;
      sxy       <= '0;
      sxx       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      it        <= '0;
      neg       <= 1'b0;
      den_zero  <= 1'b0;
      n_zero    <= 1'b0;
      q1        <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.degen <= 1'b0;
      bus.ovf   <= 1'b0;
      bus.b1    <= '0;
      bus.b0    <= '0;
      bus.cnt   <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.start) begin
        state     <= ACC;
        sx        <= '0;
        sy        <= '0;
        sxy       <= '0;
        sxx       <= '0;
        bus.cnt   <= '0;
        bus.ovf   <= 1'b0;
        bus.degen <= 1'b0;
        bus.b1    <= '0;
        bus.b0    <= '0;
        bus.busy  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          ACC: if (bus.en) begin
            if (bus.cnt == '1) begin
              bus.ovf <= 1'b1;
            end else begin
              sx      <= sx + SW'(xs);
              sy      <= sy + SW'(ys);
              sxy     <= sxy + pxy;
              sxx     <= sxx + pxx;
              bus.cnt <= bus.cnt + 1'b1;
            end
            if (bus.last) state <= PREP1;
          end
          PREP1: begin
            den_zero <= (den == '0);
            n_zero   <= (bus.cnt == '0);
            quo      <= num_mag << FRAC;
            dvs      <= den_mag;
            rem      <= '0;
            neg      <= num[IW-1] ^ den[IW-1];
            it       <= '0;
            state    <= DIV1;
          end
          DIV1, DIV2: begin
            rem <= rem_nx;
            quo <= quo_nx;
            it  <= it + 1'b1;
            if (it == LAST_IT) state <= (state == DIV1) ? PREP2 : DONE;
          end
          PREP2: begin
            q1    <= q1_c;
            quo   <= b0_mag;
            dvs   <= IW'(bus.cnt);
            rem   <= '0;
            neg   <= b0num[IW-1];
            it    <= '0;
            state <= DIV2;
          end
          DONE: begin
            bus.done  <= 1'b1;
            bus.busy  <= 1'b0;
            bus.b1    <= q1;
            bus.b0    <= n_zero ? '0 : sat(quo, neg);
            bus.degen <= den_zero;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_coef_calc.sv
// Self-checking bench for coef_calc: fixed fit vectors, abort/reset and
// overflow sequences, and random streams against a wide-integer model.
module tb_coef_calc;
  localparam int unsigned DW   = 20;
  localparam int unsigned FRAC = 10;
  localparam int unsigned CW   = 8;
  localparam int          LAT  = 195;

  logic clk = 1'b0;
  logic rst;

  coef_calc_if #(.DW(DW), .CW(CW)) bus ();

  coef_calc #(.DW(DW), .FRAC(FRAC), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int xs [5];
    int ys [5];
    int b1;
    int b0;
    bit degen;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int xq[$];
  int yq[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input bit gaps);
    for (int i = 0; i < xq.size(); i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.en = 1'b0;
        tick();
      end
      bus.en   = 1'b1;
      bus.inx  = DW'(xq[i]);
      bus.iny  = DW'(yq[i]);
      bus.last = (i == xq.size() - 1);
      tick();
    end
    bus.en   = 1'b0;
    bus.last = 1'b0;
  endtask

  task automatic wait_done(output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (bus.done) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
  endtask

  function automatic int sat_ref(input logic signed [127:0] v);
    if (v > 128'sd524287) return 524287;
    if (v < -128'sd524288) return -524288;
    return int'(v);
  endfunction

  // Closed-form least squares on the current sample queues.
  function automatic void ref_model(output int e_b1, output int e_b0, output bit e_degen,
                                    output int e_cnt, output bit e_ovf);
    logic signed [127:0] n, sx, sy, sxy, sxx, xw, yw, num, den, b1w, b0n;
    n = 0; sx = 0; sy = 0; sxy = 0; sxx = 0;
    e_ovf = 1'b0;
    foreach (xq[i]) begin
      if (n == 255) begin
        e_ovf = 1'b1;
      end else begin
        xw  = xq[i];
        yw  = yq[i];
        n   = n + 1;
        sx  = sx + xw;
        sy  = sy + yw;
        sxy = sxy + xw * yw;
        sxx = sxx + xw * xw;
      end
    end
    num = n * sxy - sx * sy;
    den = n * sxx - sx * sx;
    e_degen = (den == 0);
    e_b1 = e_degen ? 0 : sat_ref((num * 1024) / den);
    b1w  = e_b1;
    b0n  = sy - ((b1w * sx) >>> 10);
    e_b0 = (n == 0) ? 0 : sat_ref(b0n / n);
    e_cnt = int'(n);
  endfunction

  task automatic run_case(input string name, input int e_b1, input int e_b0, input bit e_degen,
                          input int e_cnt, input bit e_ovf, input bit gaps);
    int first, pulses;
    start_pulse();
    check({name, ".busy_start"}, longint'(bus.busy), 1);
    check({name, ".cnt_start"}, longint'(bus.cnt), 0);
    feed(gaps);
    wait_done(first, pulses);
    check({name, ".done_lat"}, first, LAT);
    check({name, ".done_cnt"}, pulses, 1);
    check({name, ".b1"}, longint'($signed(bus.b1)), e_b1);
    check({name, ".b0"}, longint'($signed(bus.b0)), e_b0);
    check({name, ".degen"}, longint'(bus.degen), longint'(e_degen));
    check({name, ".cnt"}, longint'(bus.cnt), e_cnt);
    check({name, ".ovf"}, longint'(bus.ovf), longint'(e_ovf));
    check({name, ".busy_end"}, longint'(bus.busy), 0);
  endtask

  task automatic load_vec(input vec_t v);
    xq.delete();
    yq.delete();
    for (int i = 0; i < v.n; i++) begin
      xq.push_back(v.xs[i]);
      yq.push_back(v.ys[i]);
    end
  endtask

  initial begin
    vec_t vecs [4];
    int first, pulses, e_b1, e_b0, e_cnt, n;
    bit e_degen, e_ovf;
    logic signed [19:0] r20;

    vecs[0] = '{4, '{0, 1024, 2048, 3072, 0}, '{1024, 3072, 5120, 7168, 0}, 2048, 1024, 1'b0};
    vecs[1] = '{5, '{0, 1024, 2048, 3072, 4096}, '{5120, 4096, 3072, 2048, 1024}, -1024, 5120, 1'b0};
    vecs[2] = '{3, '{1024, 1024, 1024, 0, 0}, '{1024, 2048, 3072, 0, 0}, 0, 2048, 1'b1};
    vecs[3] = '{1, '{3072, 0, 0, 0, 0}, '{5120, 0, 0, 0, 0}, 0, 5120, 1'b1};

    rst = 1'b0;
    bus.start = 1'b0; bus.en = 1'b0; bus.last = 1'b0; bus.inx = '0; bus.iny = '0;
    tick(); tick();
    check("rst.busy", longint'(bus.busy), 0);
    check("rst.done", longint'(bus.done), 0);
    check("rst.b1", longint'(bus.b1), 0);
    check("rst.b0", longint'(bus.b0), 0);
    check("rst.cnt", longint'(bus.cnt), 0);
    check("rst.flags", longint'({bus.degen, bus.ovf}), 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      load_vec(vecs[i]);
      run_case($sformatf("vec%0d", i), vecs[i].b1, vecs[i].b0, vecs[i].degen, vecs[i].n, 1'b0, 1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      bus.en = 1'b1; bus.inx = DW'(777); bus.iny = DW'(555);
      tick();
    end
    bus.en = 1'b0;
    check("idle_en.cnt", longint'(bus.cnt), 1);

    // Reset while DIV1 is running.
    load_vec(vecs[0]);
    start_pulse();
    feed(1'b0);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b0;
    #1;
    check("abort_rst.cnt", longint'(bus.cnt), 0);
    check("abort_rst.busy", longint'(bus.busy), 0);
    check("abort_rst.outs", longint'({bus.done, bus.degen, bus.ovf, bus.b1, bus.b0}), 0);
    tick();
    rst = 1'b1;
    wait_done(first, pulses);
    check("abort_rst.no_done", pulses, 0);

    // New start while DIV2 of an earlier stream is in progress.
    load_vec(vecs[1]);
    start_pulse();
    feed(1'b0);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("abort_start.no_done", pulses, 0);
    load_vec(vecs[0]);
    run_case("abort_start", 2048, 1024, 1'b0, 4, 1'b0, 1'b0);

    xq.delete();
    yq.delete();
    for (int i = 0; i < 256; i++) begin
      xq.push_back(1024);
      yq.push_back(1024);
    end
    run_case("ovf", 0, 1024, 1'b1, 255, 1'b1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      xq.delete();
      yq.delete();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        case (r % 3)
          0: begin
            xq.push_back((int'($urandom_range(0, 16)) - 8) * 1024);
            yq.push_back((int'($urandom_range(0, 16)) - 8) * 1024);
          end
          1: begin
            xq.push_back(int'($urandom_range(0, 8191)) - 4096);
            yq.push_back(int'($urandom_range(0, 8191)) - 4096);
          end
          default: begin
            r20 = 20'($urandom);
            xq.push_back(int'(r20));
            r20 = 20'($urandom);
            yq.push_back(int'(r20));
          end
        endcase
      end
      ref_model(e_b1, e_b0, e_degen, e_cnt, e_ovf);
      run_case($sformatf("rand%0d", r), e_b1, e_b0, e_degen, e_cnt, e_ovf, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
